// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register with a valid/ready handshake on both sides.
// A skid slot absorbs the stall cycle, so in_ready_o depends only on registered state.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             acc, take;

  // All outputs decode straight from registered state, so no input reaches an output.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign acc  = in_valid && in_ready;
  assign take = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (acc && take) begin
          main_d = in_data;
        end else if (acc) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops the valid state; data registers keep their contents.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  always_ff @(negedge clk) begin
    skid_q <= skid_d;
  end

endmodule
